// File: rtl/dram_model_pkg.sv
// Shared defaults and sizing helpers for the on-chip memory models.
package dram_model_pkg;

  localparam int DEF_DATA_W      = 128;
  localparam int DEF_ID_W        = 4;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DEPTH_LINES = 1024;
  localparam int DEF_LATENCY     = 8;
  localparam int DEF_QUEUE_DEPTH = 4;

  // Response entry layout: tag in the low bits, line data directly above it.
  localparam int RESP_ID_LSB = 0;

  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int idx_bits(input int depth_lines);
    return (depth_lines > 1) ? $clog2(depth_lines) : 1;
  endfunction

  function automatic int resp_data_lsb(input int id_w);
    return RESP_ID_LSB + id_w;
  endfunction

  function automatic int resp_entry_w(input int id_w, input int data_w);
    return id_w + data_w;
  endfunction

endpackage

// File: rtl/dram_resp_fifo.sv
// Synchronous response FIFO. out_valid is a flop; out_data is the entry under
// the registered read pointer, so both hold steady until a pop.
module dram_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          do_pop;

  assign do_pop   = pop && out_valid;
  assign out_data = store[rd_ptr];

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count;
    case ({push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage, pointers and registered valid; storage cleared so outputs read zero out of reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else begin
      if (push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
    end
  end

  // Upstream credit must keep pushes within capacity
  always @(posedge clock) begin
    if (!reset) assert (!(push && !do_pop && count == FULL));
  end

endmodule

// File: rtl/dram_latency_model.sv
// Fixed-latency DRAM stand-in: line array with byte-masked writes, a
// non-stalling delay pipe, a response FIFO and a credit counter that bounds
// outstanding requests so the FIFO can never overflow.
module dram_latency_model
  import dram_model_pkg::*;
#(
  parameter int    DATA_W      = DEF_DATA_W,
  parameter int    ID_W        = DEF_ID_W,
  parameter int    ADDR_W      = DEF_ADDR_W,
  parameter int    DEPTH_LINES = DEF_DEPTH_LINES,
  parameter int    LATENCY     = DEF_LATENCY,
  parameter int    QUEUE_DEPTH = DEF_QUEUE_DEPTH,
  parameter string INIT_FILE   = ""
) (
  input  logic                clock,
  input  logic                reset,
  output logic                req_ready,
  input  logic                req_valid,
  input  logic [ID_W-1:0]     req_bits_id,
  input  logic [ADDR_W-1:0]   req_bits_addr,
  input  logic [DATA_W-1:0]   req_bits_data,
  input  logic                req_bits_isWr,
  input  logic [DATA_W/8-1:0] req_bits_mask,
  input  logic                resp_ready,
  output logic                resp_valid,
  output logic [ID_W-1:0]     resp_bits_id,
  output logic [DATA_W-1:0]   resp_bits_data
);

  localparam int OFF  = off_bits(DATA_W);
  localparam int IW   = idx_bits(DEPTH_LINES);
  localparam int NB   = DATA_W / 8;
  localparam int CW   = $clog2(QUEUE_DEPTH + 1);
  localparam int EW   = resp_entry_w(ID_W, DATA_W);
  localparam int DLSB = resp_data_lsb(ID_W);
  localparam logic [CW-1:0] QD = CW'(QUEUE_DEPTH);

  logic [DATA_W-1:0]                mem [DEPTH_LINES];
  logic [IW-1:0]                    line_idx;
  logic                             accept, pop;
  logic [CW-1:0]                    outstanding;
  logic [LATENCY-1:0]               vld_pipe;
  logic [LATENCY-1:0][ID_W-1:0]     id_pipe;
  logic [LATENCY-1:0][DATA_W-1:0]   data_pipe;
  logic [EW-1:0]                    push_entry, head_entry;
  logic                             addr_unused;

  // Offset bits and bits above the index are don't-care; high bits alias.
  assign line_idx    = req_bits_addr[OFF +: IW];
  assign addr_unused = ^req_bits_addr;

  assign req_ready = !reset && (outstanding < QD);
  assign accept    = req_valid && req_ready;
  assign pop       = resp_valid && resp_ready;

  // Backing array: merge write bytes where mask is set; contents survive reset
  always_ff @(posedge clock) begin
    if (accept && req_bits_isWr) begin
      for (int b = 0; b < NB; b++)
        if (req_bits_mask[b]) mem[line_idx][b*8 +: 8] <= req_bits_data[b*8 +: 8];
    end
  end

  // Delay-pipe valids: shift every cycle, dropped on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      for (int k = 1; k < LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // Delay-pipe payload: read line sampled at accept (earlier writes already landed), write acks carry zero
  always_ff @(posedge clock) begin
    id_pipe[0]   <= req_bits_id;
    data_pipe[0] <= req_bits_isWr ? '0 : mem[line_idx];
    for (int k = 1; k < LATENCY; k++) begin
      id_pipe[k]   <= id_pipe[k-1];
      data_pipe[k] <= data_pipe[k-1];
    end
  end

  assign push_entry = {data_pipe[LATENCY-1], id_pipe[LATENCY-1]};

  dram_resp_fifo #(
    .W     (EW),
    .DEPTH (QUEUE_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (vld_pipe[LATENCY-1]),
    .push_data (push_entry),
    .pop       (resp_ready),
    .out_valid (resp_valid),
    .out_data  (head_entry)
  );

  assign resp_bits_id   = head_entry[RESP_ID_LSB +: ID_W];
  assign resp_bits_data = head_entry[DLSB +: DATA_W];

  // Credit counter: requests accepted but not yet popped
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Credit bookkeeping must stay within 0..QUEUE_DEPTH
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(pop && !accept && outstanding == '0));
      assert (outstanding <= QD);
    end
  end

endmodule
